// File: rtl/fetch_redirect_ctrl.sv
// Front-end fetch sequencer. It owns the fetch PC and issues icache requests.
// In-flight requests are tracked in an in-order PC queue. Stale responses left
// over after a trap, mret or branch redirect are drained and dropped. It also
// parks fetch while the core sleeps on WFI.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          OUT_CNT_WIDTH   = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trap_i,
  input  logic        mret_i,
  input  logic [31:0] trap_vector_i,
  input  logic [31:0] mret_vector_i,
  input  logic        branch_valid_i,
  input  logic [31:0] branch_target_i,
  input  logic        wfi_i,
  input  logic        irq_pending_i,
  input  logic        predict_valid_i,
  input  logic [31:0] predict_target_i,
  input  logic        buffer_full_i,
  input  logic        icache_req_ready_i,
  output logic        icache_req_valid_o,
  output logic [31:0] pc_o,
  input  logic        icache_resp_valid_i,
  output logic        icache_resp_ready_o,
  output logic        resp_accept_o,
  output logic        resp_drop_o,
  output logic [31:0] resp_pc_o,
  output logic        flush_o,
  output logic        exception_valid_o,
  output logic [1:0]  state_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [31:0]              pc_q, pc_d;
  logic [31:0]              redir_tgt;
  logic [OUT_CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [31:0]              pc_queue [MAX_OUTSTANDING];
  logic [PTR_W-1:0]         rd_ptr_q, wr_ptr_q;
  logic                     redirect, req_hs, resp_hs, pop;

  // Any redirect source wins over fetch. Trap has the highest priority, then mret, then branch.
  assign redirect  = trap_i | mret_i | branch_valid_i;
  assign redir_tgt = trap_i ? trap_vector_i :
                     mret_i ? mret_vector_i : branch_target_i;

  // Requests are held back while in reset so the icache never sees a request
  // from an un-initialised fetch path.
  assign icache_req_valid_o = reset_n & (state_q == RUN) & ~buffer_full_i &
                              (out_cnt_q < OUT_CNT_WIDTH'(MAX_OUTSTANDING)) &
                              ~redirect & (pc_q[1:0] == 2'b00);
  assign exception_valid_o  = (state_q == RUN) & (pc_q[1:0] != 2'b00);

  // Stale responses must always drain, even when the buffer is full.
  assign icache_resp_ready_o = (state_q == DRAIN) | redirect | ~buffer_full_i;

  assign req_hs  = icache_req_valid_o & icache_req_ready_i;
  assign resp_hs = icache_resp_valid_i & icache_resp_ready_o;

  assign resp_accept_o = resp_hs & (state_q != DRAIN) & ~redirect;
  assign resp_drop_o   = resp_hs & ((state_q == DRAIN) | redirect);
  assign resp_pc_o     = pc_queue[rd_ptr_q];
  assign flush_o       = redirect;
  assign pc_o          = pc_q;
  assign state_o       = state_q;

  // Guard against popping an empty queue on a spurious response.
  assign pop = resp_accept_o & (out_cnt_q != '0);

  // Outstanding count: it rises on a request and falls on any response,
  // including dropped ones. It saturates at zero on a spurious response.
  always_comb begin
    out_cnt_d = out_cnt_q;
    if (req_hs && !resp_hs)
      out_cnt_d = out_cnt_q + OUT_CNT_WIDTH'(1);
    else if (!req_hs && resp_hs && out_cnt_q != '0)
      out_cnt_d = out_cnt_q - OUT_CNT_WIDTH'(1);
  end

  // Next fetch PC: a redirect target, else the prediction or the sequential PC after a handshake.
  always_comb begin
    pc_d = pc_q;
    if (redirect)
      pc_d = redir_tgt;
    else if (req_hs)
      pc_d = predict_valid_i ? predict_target_i : pc_q + 32'd4;
  end

  // State transitions. A redirect enters DRAIN only when responses remain in flight.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = (out_cnt_d != '0) ? DRAIN : RUN;
    end else begin
      case (state_q)
        RUN:     if (wfi_i) state_d = SLEEP;
        DRAIN:   if (resp_hs && out_cnt_q == OUT_CNT_WIDTH'(1)) state_d = RUN;
        SLEEP:   if (irq_pending_i) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // State, PC and outstanding-count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      pc_q      <= RESET_VECTOR;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // In-order PC queue. A redirect empties it; stale responses then only decrement the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) pc_queue[i] <= '0;
    end else if (redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (req_hs) begin
        pc_queue[wr_ptr_q] <= pc_q;
        wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

endmodule
